// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory.
// Holds the controller state encoding and default geometry.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_DATA_W  = 8;
    localparam int DMEM_LATENCY = 5;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte storage with a registered read port.
// A clear wipes every byte and the read register in one edge.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage: clear has priority over the write port.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: holds its value until the next enabled read.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Slow byte-addressed data memory with a busywait handshake.
// Requests are captured in IDLE and serviced after LATENCY edges.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;

    logic              fire_d;
    logic              we_d;
    logic              re_d;

    // Access happens on the edge that ends the last BUSY cycle.
    always_comb begin
        fire_d = (state_q == BUSY) && (cnt_q == '0);
        we_d   = fire_d && wr_q;
        re_d   = fire_d && !wr_q;
    end

    // Stall the CPU from the very cycle a request shows up.
    always_comb begin
        BUSYWAIT = ((state_q == IDLE) && (READ || WRITE))
                 || (state_q == BUSY);
    end

    // Controller: capture, count down, then one dead DONE cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (READ || WRITE) begin
                        addr_q  <= ADDRESS;
                        data_q  <= WRITEDATA;
                        wr_q    <= WRITE;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i   (CLK),
        .clr_i   (RESET),
        .we_i    (we_d),
        .re_i    (re_d),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (READDATA)
    );

endmodule
